// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier.
// Each RUN cycle adds one partial product, so a result takes WIDTH cycles
// after acceptance. With SIGNED=1 the operands are converted to
// sign-magnitude form. The unsigned magnitudes are multiplied, and the
// product is negated at the end when the operand signs differ.
module seq_shift_add_multiplier #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   sum;

  // Magnitude of an operand. The most negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    if ((SIGNED != 0) && x[WIDTH-1]) begin
      return -x;
    end
    return x;
  endfunction

  // Restore the sign of the product in 2*WIDTH-bit two's complement.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] x,
                                                    input logic n);
    return n ? -x : x;
  endfunction

  // Next-state logic: accept in IDLE/DONE, then run one partial product per cycle
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    done_d   = 1'b0;
    addend   = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
    sum      = acc_q + addend;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mcand_d  = magnitude(a);
          mplier_d = magnitude(b);
          neg_d    = (SIGNED != 0) ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d    = sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          p_d     = apply_sign(sum, neg_q);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State and datapath registers; reset clears everything, asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule
